// File: rtl/dcache_datapath.sv
// Direct-mapped data-cache datapath: flop-based tag/valid/dirty/line storage with combinational lookup.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_datapath #(
    parameter int LINE_SIZE = 32,
    parameter int OFS_SIZE  = 5,
    parameter int SET_SIZE  = 5,
    parameter int TAG_SIZE  = 22,
    parameter int NUM_SETS  = 32,
    parameter int XLEN      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [XLEN-1:0]        req_addr,
    input  logic                   req_write_en,
    input  logic [XLEN-1:0]        req_wdata,
    input  logic [XLEN/8-1:0]      req_wstrb,
    input  logic                   fill_en,
    input  logic [LINE_SIZE*8-1:0] fill_line,
    output logic                   hit,
    output logic [XLEN-1:0]        rd_data,
    output logic                   victim_dirty,
    output logic [XLEN-1:0]        victim_addr,
    output logic [LINE_SIZE*8-1:0] victim_line
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int LW   = LINE_SIZE * 8;
    localparam int BPW  = XLEN / 8;
    localparam int WB   = $clog2(BPW);
    localparam int WIDX = OFS_SIZE - WB;

    logic [SET_SIZE-1:0] set;
    logic [TAG_SIZE-1:0] tag;
    logic [WIDX-1:0]     widx;

    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [NUM_SETS-1:0] dirty_q, dirty_d;
    logic [TAG_SIZE-1:0] tag_q  [NUM_SETS];
    logic [LW-1:0]       line_q [NUM_SETS];

    logic [LW-1:0]       cur_line;
    logic [LW-1:0]       base_line;
    logic [LW-1:0]       line_d;
    logic                store_hit;
    logic                store_alloc;
    logic                line_we;

    function automatic logic [XLEN-1:0] merge_word(input logic [XLEN-1:0] old_w,
                                                   input logic [XLEN-1:0] new_w,
                                                   input logic [BPW-1:0]  strb);
        logic [XLEN-1:0] r;
        r = old_w;
        for (int b = 0; b < BPW; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    assign set  = req_addr[OFS_SIZE +: SET_SIZE];
    assign tag  = req_addr[XLEN-1 -: TAG_SIZE];
    assign widx = req_addr[WB +: WIDX];

    assign cur_line     = line_q[set];
    assign hit          = valid_q[set] && (tag_q[set] == tag);
    assign rd_data      = cur_line[widx*XLEN +: XLEN];
    assign victim_dirty = valid_q[set] & dirty_q[set];
    assign victim_addr  = {tag_q[set], set, {OFS_SIZE{1'b0}}};
    assign victim_line  = cur_line;

    // A store together with a fill merges over the incoming line (write-allocate).
    always_comb begin
        store_hit   = req_valid & req_write_en & hit & ~fill_en;
        store_alloc = fill_en & req_valid & req_write_en;
        line_we     = fill_en | store_hit;
        base_line   = fill_en ? fill_line : cur_line;
        line_d      = base_line;
        if (store_hit || store_alloc) begin
            line_d[widx*XLEN +: XLEN] = merge_word(base_line[widx*XLEN +: XLEN],
                                                   req_wdata, req_wstrb);
        end
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            valid_d[set] = 1'b1;
            dirty_d[set] = store_alloc;
        end else if (store_hit) begin
            dirty_d[set] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data are not reset, but a reset cycle still blocks their update.
    always_ff @(posedge clk) begin
        if (!reset && line_we) line_q[set] <= line_d;
        if (!reset && fill_en) tag_q[set]  <= tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (req_valid) begin
            if (hit) begin
                if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
            end else begin
                if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_datapath.sv
// Self-checking bench for dcache_datapath: directed scenarios plus random traffic against a byte-array model.
// Statistics checks are compiled in when DCACHE_STATS_EN is defined.
module tb_dcache_datapath;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_write_en;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         fill_en;
    logic [255:0] fill_line;
    logic         hit;
    logic [31:0]  rd_data;
    logic         victim_dirty;
    logic [31:0]  victim_addr;
    logic [255:0] victim_line;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    always #5 clk = ~clk;

    dcache_datapath dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_write_en(req_write_en), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .fill_en(fill_en), .fill_line(fill_line), .hit(hit), .rd_data(rd_data),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Reference model: per-set bytes plus bookkeeping.
    logic [7:0]  m_mem   [32][32];
    logic        m_valid [32];
    logic        m_dirty [32];
    logic        m_known [32];
    logic [21:0] m_tag   [32];
    int unsigned m_hits, m_misses;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int a_set(input logic [31:0] a); return int'(a[9:5]);  endfunction
    function automatic logic [21:0] a_tag(input logic [31:0] a); return a[31:10]; endfunction
    function automatic int a_word(input logic [31:0] a); return int'(a[4:2]); endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[a_set(a)] && (m_tag[a_set(a)] == a_tag(a));
    endfunction

    function automatic logic [255:0] m_line(input int s);
        logic [255:0] l;
        for (int i = 0; i < 32; i++) l[i*8 +: 8] = m_mem[s][i];
        return l;
    endfunction

    function automatic logic [31:0] m_word(input int s, input int w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_mem[s][w*4 + i];
        return r;
    endfunction

    task automatic apply(input logic rst, input logic v, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] ws, input logic f,
                         input logic [255:0] fl);
        int s;
        reset = rst; req_valid = v; req_addr = a; req_write_en = we;
        req_wdata = wd; req_wstrb = ws; fill_en = f; fill_line = fl;
        #1;
        s = a_set(a);
        chk("hit", {255'd0, hit}, {255'd0, m_hit(a)});
        chk("victim_dirty", {255'd0, victim_dirty}, {255'd0, m_valid[s] & m_dirty[s]});
        if (m_known[s]) begin
            chk("rd_data", {224'd0, rd_data}, {224'd0, m_word(s, a_word(a))});
            chk("victim_line", victim_line, m_line(s));
            chk("victim_addr", {224'd0, victim_addr}, {224'd0, m_tag[s], a[9:5], 5'd0});
        end
`ifdef DCACHE_STATS_EN
        chk("hit_count", {224'd0, hit_count}, {224'd0, m_hits});
        chk("miss_count", {224'd0, miss_count}, {224'd0, m_misses});
`endif
    endtask

    task automatic tick;
        int  s, w;
        logic h, st;
        s  = a_set(req_addr);
        w  = a_word(req_addr);
        h  = m_hit(req_addr);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
            m_hits = 0; m_misses = 0;
        end else begin
            if (req_valid) begin
                if (h) begin if (m_hits != 32'hFFFF_FFFF) m_hits++; end
                else   begin if (m_misses != 32'hFFFF_FFFF) m_misses++; end
            end
            st = req_valid && req_write_en && (fill_en || h);
            if (fill_en) begin
                for (int i = 0; i < 32; i++) m_mem[s][i] = fill_line[i*8 +: 8];
                m_tag[s] = a_tag(req_addr); m_valid[s] = 1'b1; m_dirty[s] = 1'b0; m_known[s] = 1'b1;
            end
            if (st) begin
                for (int i = 0; i < 4; i++)
                    if (req_wstrb[i]) m_mem[s][w*4 + i] = req_wdata[i*8 +: 8];
                m_dirty[s] = 1'b1;
            end
        end
        #1;
    endtask

    function automatic logic [255:0] rand_line;
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        logic [255:0] fl;
        logic [31:0]  a;
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_known[i] = 1'b0; m_tag[i] = '0;
        end
        m_hits = 0; m_misses = 0;

        // Reset with a fill and store pending: reset wins.
        apply(1, 1, 32'h0000_1040, 1, 32'h5555_5555, 4'hF, 1, rand_line());
        tick();
        apply(0, 0, 32'h0000_0040, 0, 0, 0, 0, '0);
        chk("reset_hit", {255'd0, hit}, 256'd0);
        chk("reset_vdirty", {255'd0, victim_dirty}, 256'd0);
        apply(0, 0, 32'h0000_1040, 0, 0, 0, 0, '0);
        chk("reset_prio_hit", {255'd0, hit}, 256'd0);

        fl = rand_line();
        fl[95:64] = 32'hDEAD_BEEF;
        apply(0, 1, 32'h0000_1040, 0, 0, 0, 1, fl);
        tick();
        apply(0, 1, 32'h0000_1048, 0, 0, 0, 0, '0);
        chk("fill_hit", {255'd0, hit}, 256'd1);
        chk("fill_rd", {224'd0, rd_data}, {224'd0, 32'hDEAD_BEEF});
        chk("fill_vdirty", {255'd0, victim_dirty}, 256'd0);

        apply(0, 1, 32'h0000_1048, 1, 32'h1122_3344, 4'b0011, 0, '0);
        tick();
        apply(0, 1, 32'h0000_1048, 0, 0, 0, 0, '0);
        chk("store_rd", {224'd0, rd_data}, {224'd0, 32'hDEAD_3344});
        chk("store_vdirty", {255'd0, victim_dirty}, 256'd1);

        apply(0, 1, 32'h0000_2048, 1, 32'h9999_9999, 4'hF, 0, '0);
        chk("conf_hit", {255'd0, hit}, 256'd0);
        chk("conf_vdirty", {255'd0, victim_dirty}, 256'd1);
        chk("conf_vaddr", {224'd0, victim_addr}, {224'd0, 32'h0000_1040});
        chk("conf_vword2", {224'd0, victim_line[95:64]}, {224'd0, 32'hDEAD_3344});
        tick();  // store on miss without fill: ignored
        apply(0, 1, 32'h0000_1048, 0, 0, 0, 0, '0);
        chk("miss_store_ign", {224'd0, rd_data}, {224'd0, 32'hDEAD_3344});

        apply(0, 1, 32'h0000_2048, 1, 32'hCAFE_F00D, 4'hF, 1, rand_line());
        tick();
        apply(0, 1, 32'h0000_2048, 0, 0, 0, 0, '0);
        chk("alloc_hit", {255'd0, hit}, 256'd1);
        chk("alloc_rd", {224'd0, rd_data}, {224'd0, 32'hCAFE_F00D});
        chk("alloc_dirty", {255'd0, victim_dirty}, 256'd1);
        apply(1, 0, 32'h0000_2048, 0, 0, 0, 0, '0);
        tick();
        apply(0, 0, 32'h0000_2048, 0, 0, 0, 0, '0);
        chk("rst2_hit", {255'd0, hit}, 256'd0);

`ifdef DCACHE_STATS_EN
        apply(0, 0, 32'h0000_3000, 0, 0, 0, 1, rand_line());
        tick();
        apply(0, 1, 32'h0000_3004, 0, 0, 0, 0, '0); tick();
        apply(0, 1, 32'h0000_3008, 0, 0, 0, 0, '0); tick();
        apply(0, 1, 32'h0000_4000, 0, 0, 0, 0, '0); tick();
        apply(0, 1, 32'h0000_5000, 0, 0, 0, 0, '0); tick();
        apply(0, 1, 32'h0000_6000, 0, 0, 0, 0, '0); tick();
        apply(0, 0, 32'h0000_3000, 0, 0, 0, 0, '0);
        chk("stats_hits", {224'd0, hit_count}, 256'd2);
        chk("stats_misses", {224'd0, miss_count}, 256'd3);
        apply(1, 0, 32'h0, 0, 0, 0, 0, '0); tick();
        apply(0, 0, 32'h0, 0, 0, 0, 0, '0);
        chk("stats_rst_h", {224'd0, hit_count}, 256'd0);
        chk("stats_rst_m", {224'd0, miss_count}, 256'd0);
`endif

        // Random traffic over a few sets and tags to provoke hits, conflicts and merges.
        for (int n = 0; n < 600; n++) begin
            a = {20'd0, 2'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 5'($urandom)};
            apply(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0, a,
                  $urandom_range(0, 1) == 1, $urandom, 4'($urandom),
                  $urandom_range(0, 4) == 0, rand_line());
            tick();
        end
        apply(0, 0, 32'h0, 0, 0, 0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_datapath.md
DCACHE_DATAPATH -- requirements
Module: dcache_datapath

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 32, meaning bytes per cache line.
REQ-002 SHALL have parameter OFS_SIZE, default 5, meaning log2(LINE_SIZE) offset bits.
REQ-003 SHALL have parameter SET_SIZE, default 5, meaning log2(NUM_SETS) index bits.
REQ-004 SHALL have parameter TAG_SIZE, default 22, meaning XLEN-(SET_SIZE+OFS_SIZE) tag bits.
REQ-005 SHALL have parameter NUM_SETS, default 32, meaning number of lines (direct-mapped).
REQ-006 SHALL have parameter XLEN, default 32, meaning address/data word width in bits.
REQ-007 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-008 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports: req_valid  in  1  request present this cycle.
REQ-010 SHALL have ports: req_addr  in  XLEN  byte address; offset=[OFS_SIZE-1:0], set=next SET_SIZE bits, tag=top TAG_SIZE bits.
REQ-011 SHALL have ports: req_write_en  in  1  request is a store; req_wdata  in  XLEN  store data; req_wstrb  in  XLEN/8  byte enables.
REQ-012 SHALL have ports: fill_en  in  1  install line; fill_line  in  LINE_SIZE*8  line data from memory (byte 0 in LSBs).
REQ-013 SHALL have ports: hit  out  1; rd_data  out  XLEN; victim_dirty  out  1; victim_addr  out  XLEN; victim_line  out  LINE_SIZE*8.

Function
REQ-014 SHALL hold per set: valid bit, dirty bit, TAG_SIZE tag, LINE_SIZE-byte data, all in flops.
REQ-015 SHALL drive hit combinationally = valid[set] AND stored tag == req tag, independent of req_valid.
REQ-016 SHALL drive rd_data combinationally = word of set's line selected by offset bits above the byte-in-word bits (offset low bits ignored, word-aligned), regardless of hit.
REQ-017 SHALL drive victim_dirty = valid[set] AND dirty[set]; victim_addr = {stored tag, set, zero offset}; victim_line = stored line, all combinational.
REQ-018 SHALL, when req_valid & req_write_en & hit & !fill_en, write bytes with req_wstrb set into the addressed word at the next edge and set dirty; other bytes unchanged.
REQ-019 SHALL, when fill_en, at the next edge write fill_line, set tag to req tag, set valid, clear dirty.
REQ-020 SHALL, when fill_en and req_valid & req_write_en in the same cycle, write fill_line with the strobed store bytes merged over it and set dirty (write-allocate).
REQ-021 SHALL ignore stores on miss without fill (no state change).
REQ-022 SHALL make updates visible on hit/rd_data in the cycle after the edge (1-cycle write latency, 0-cycle read latency).

Reset
REQ-023 SHALL clear all valid and dirty bits on reset; tag and data contents are not reset.
REQ-024 SHALL give hit=0 and victim_dirty=0 for every address after reset.
REQ-025 SHALL give reset priority over fill and store in the same cycle (neither takes effect).

Configuration
REQ-026 SHALL, with DCACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each), reset to 0, incrementing on each req_valid cycle with hit=1 or hit=0 respectively, saturating at all-ones.
REQ-027 SHALL, without DCACHE_STATS_EN, omit those ports and counters with identical remaining behaviour.

Verification
REQ-028 SHALL verify: reset, then req_addr=0x00000040 -> hit=0, victim_dirty=0.
REQ-029 SHALL verify: fill_en with fill_line word2=0xDEADBEEF at addr 0x00001040 -> next cycle read 0x00001048 gives hit=1, rd_data=0xDEADBEEF, victim_dirty=0.
REQ-030 SHALL verify: store 0x11223344 wstrb=0b0011 to 0x00001048 -> rd_data=0xDEAD3344, victim_dirty=1.
REQ-031 SHALL verify: read conflicting 0x00002048 (same set) -> hit=0, victim_dirty=1, victim_addr=0x00001040, victim_line contains 0xDEAD3344 at word2.
REQ-032 SHALL verify: fill plus store same cycle at 0x00002048, wdata 0xCAFEF00D, wstrb=0xF -> hit=1, rd_data=0xCAFEF00D, dirty=1; then reset -> hit=0.
REQ-033 SHALL verify with DCACHE_STATS_EN: 2 hits + 3 misses -> hit_count=2, miss_count=3; reset -> both 0.
